// File: rtl/ft245_bus_bridge_pkg.sv
// Shared types and constants for the FT245 bus bridge.
package ft245_pkg;

  typedef enum logic [1:0] {B_IDLE, B_ACK, B_END} bus_state_t;
  typedef enum logic [1:0] {R_IDLE, R_STROBE, R_RECOVER} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_SETUP, T_PULSE, T_HOLD, T_RECOVER} tx_state_t;

  // Page decodes: serial pages match on A[19:13], status pages on A[19:12]
  localparam logic [6:0] SER_IN_PG  = 7'h3C;
  localparam logic [6:0] SER_OUT_PG = 7'h3D;
  localparam logic [7:0] RDF_PG     = 8'h7C;
  localparam logic [7:0] TXE_PG     = 8'h7D;

  // Default strobe timing in clk cycles
  localparam int unsigned DEF_RD_PULSE = 3;
  localparam int unsigned DEF_WR_PULSE = 2;
  localparam int unsigned DEF_RECOVERY = 2;

endpackage

// File: rtl/ft245_bus_bridge_rx_fifo.sv
// Synchronous RX byte buffer; depth must be a power of two so pointers wrap naturally.
module rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic [7:0]               o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/ft245_bus_bridge.sv
// 68000 bus to FT245 FIFO bridge: CPU page decode/_dtack, RX drain engine, TX strobe engine.
module ft245_bus_bridge
  import ft245_pkg::*;
#(
  parameter int unsigned RD_PULSE = DEF_RD_PULSE,
  parameter int unsigned WR_PULSE = DEF_WR_PULSE,
  parameter int unsigned RECOVERY = DEF_RECOVERY,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic [7:0] addr,
  input  logic       _as,
  input  logic       _ds,
  input  logic       rw,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_doe,
  output logic       _dtack,
  input  logic       _rdf,
  input  logic       _txe,
  input  logic [7:0] fifo_din,
  output logic [7:0] fifo_dout,
  output logic       fifo_oe,
  output logic       _rd,
  output logic       wr,
  output logic       irq_rx
);

  bus_state_t r_bus, w_bus_nxt;
  rx_state_t  r_rx,  w_rx_nxt;
  tx_state_t  r_tx,  w_tx_nxt;

  logic [4:0] r_sync1, r_sync2;
  logic       w_as_n, w_ds_n, w_rw, w_rdf_n, w_txe_n;
  logic [7:0] r_rx_cnt, w_rx_cnt_nxt, r_tx_cnt, w_tx_cnt_nxt;
  logic [7:0] r_cpu_dout, w_dout_nxt, r_hold, r_fifo_dout;
  logic       r_rw, w_rw_nxt, r_hold_valid, r_irq;
  logic       w_pop, w_push, w_hold_set, w_hold_clr, w_tx_load;
  logic       w_hit_in, w_hit_out, w_hit_rdf, w_hit_txe, w_hit, w_stall;
  logic       w_tx_start, w_rx_start;
  logic [7:0] w_rx_head;
  logic       w_empty, w_full;
  logic [$clog2(RX_DEPTH):0] w_count;

  // Two-flop synchronizers for every asynchronous strobe/flag (idle = high)
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {_as, _ds, rw, _rdf, _txe};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_as_n, w_ds_n, w_rw, w_rdf_n, w_txe_n} = r_sync2;

  assign w_hit_in  = (addr[7:1] == SER_IN_PG);
  assign w_hit_out = (addr[7:1] == SER_OUT_PG);
  assign w_hit_rdf = (addr == RDF_PG);
  assign w_hit_txe = (addr == TXE_PG);
  assign w_hit     = w_hit_in | w_hit_out | w_hit_rdf | w_hit_txe;
  assign w_stall   = !w_rw && w_hit_out && r_hold_valid;

  // Engine arbitration: only one FIFO strobe engine active; TX wins a tie
  assign w_tx_start = (r_tx == T_IDLE) && r_hold_valid && !w_txe_n && (r_rx == R_IDLE);
  assign w_rx_start = (r_rx == R_IDLE) && !w_rdf_n && !w_full && (r_tx == T_IDLE) && !w_tx_start;

  rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (_reset),
    .i_push  (w_push),
    .i_din   (fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_rx_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // State, counter and data registers for all three engines
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_bus        <= B_IDLE;
      r_rx         <= R_IDLE;
      r_tx         <= T_IDLE;
      r_rx_cnt     <= '0;
      r_tx_cnt     <= '0;
      r_cpu_dout   <= '0;
      r_rw         <= 1'b0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_fifo_dout  <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_bus      <= w_bus_nxt;
      r_rx       <= w_rx_nxt;
      r_tx       <= w_tx_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_cpu_dout <= w_dout_nxt;
      r_rw       <= w_rw_nxt;
      r_irq      <= !w_empty;
      if (w_tx_load) r_fifo_dout <= r_hold;
      if (w_hold_set) begin
        r_hold       <= cpu_din;
        r_hold_valid <= 1'b1;
      end else if (w_hold_clr) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  // Bus FSM: accept decoded cycles, produce read data, stall writes while hold is full
  always_comb begin
    w_bus_nxt  = r_bus;
    w_dout_nxt = r_cpu_dout;
    w_rw_nxt   = r_rw;
    w_pop      = 1'b0;
    w_hold_set = 1'b0;
    case (r_bus)
      B_IDLE: begin
        if (!w_as_n && !w_ds_n && w_hit && !w_stall) begin
          w_bus_nxt = B_ACK;
          w_rw_nxt  = w_rw;
          if (w_rw) begin
            if (w_hit_in) begin
              w_dout_nxt = w_empty ? 8'hFF : w_rx_head;
              w_pop      = !w_empty;
            end else if (w_hit_rdf) begin
              w_dout_nxt = {7'b0, (w_count == '0)};
            end else if (w_hit_txe) begin
              w_dout_nxt = {7'b0, r_hold_valid};
            end else begin
              w_dout_nxt = 8'h00;
            end
          end else if (w_hit_out) begin
            w_hold_set = 1'b1;
          end
        end
      end
      B_ACK:   w_bus_nxt = B_END;
      B_END:   if (w_as_n) w_bus_nxt = B_IDLE;
      default: w_bus_nxt = B_IDLE;
    endcase
  end

  // RX FSM: strobe _rd, push the byte on the last low cycle, then recover
  always_comb begin
    w_rx_nxt     = r_rx;
    w_rx_cnt_nxt = r_rx_cnt;
    w_push       = 1'b0;
    case (r_rx)
      R_IDLE: begin
        if (w_rx_start) begin
          w_rx_nxt     = R_STROBE;
          w_rx_cnt_nxt = '0;
        end
      end
      R_STROBE: begin
        if (r_rx_cnt == 8'(RD_PULSE - 1)) begin
          w_rx_nxt     = R_RECOVER;
          w_rx_cnt_nxt = '0;
          w_push       = 1'b1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 8'd1;
        end
      end
      R_RECOVER: begin
        if (r_rx_cnt == 8'(RECOVERY - 1)) begin
          w_rx_nxt     = R_IDLE;
          w_rx_cnt_nxt = '0;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 8'd1;
        end
      end
      default: w_rx_nxt = R_IDLE;
    endcase
  end

  // TX FSM: drive data, pulse wr, keep data one cycle past the falling edge, recover
  always_comb begin
    w_tx_nxt     = r_tx;
    w_tx_cnt_nxt = r_tx_cnt;
    w_tx_load    = 1'b0;
    w_hold_clr   = 1'b0;
    case (r_tx)
      T_IDLE: begin
        if (w_tx_start) begin
          w_tx_nxt  = T_SETUP;
          w_tx_load = 1'b1;
        end
      end
      T_SETUP: begin
        w_tx_nxt     = T_PULSE;
        w_tx_cnt_nxt = '0;
      end
      T_PULSE: begin
        if (r_tx_cnt == 8'(WR_PULSE - 1)) begin
          w_tx_nxt     = T_HOLD;
          w_tx_cnt_nxt = '0;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 8'd1;
        end
      end
      T_HOLD: begin
        w_tx_nxt     = T_RECOVER;
        w_tx_cnt_nxt = '0;
        w_hold_clr   = 1'b1;
      end
      T_RECOVER: begin
        if (r_tx_cnt == 8'(RECOVERY - 1)) begin
          w_tx_nxt     = T_IDLE;
          w_tx_cnt_nxt = '0;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 8'd1;
        end
      end
      default: w_tx_nxt = T_IDLE;
    endcase
  end

  assign _dtack    = !((r_bus == B_ACK) || (r_bus == B_END));
  assign cpu_doe   = r_rw && (r_bus != B_IDLE);
  assign cpu_dout  = r_cpu_dout;
  assign _rd       = (r_rx != R_STROBE);
  assign wr        = (r_tx == T_PULSE);
  assign fifo_oe   = (r_tx == T_SETUP) || (r_tx == T_PULSE) || (r_tx == T_HOLD);
  assign fifo_dout = r_fifo_dout;
  assign irq_rx    = r_irq;

endmodule
